threshold_parity_eval: RTL and testbench
========================================

THRESHOLD_PARITY_EVAL -- requirements
Module: threshold_parity_eval

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of input bits per operand.
REQ-002 The block SHALL have parameter LANES, default 1: bits consumed per cycle; WIDTH SHALL be a multiple of LANES, with elaboration error otherwise.
REQ-003 The block SHALL use derived constants: CW = clog2(WIDTH+1) and NBEATS = WIDTH/LANES.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  operand offered.
REQ-007 in_ready  out  1  block can accept an operand.
REQ-008 in_data  in  WIDTH  operand bits.
REQ-009 in_thr  in  CW  threshold for this operand, latched at accept.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes result.
REQ-012 out_count  out  CW  popcount of operand.
REQ-013 out_parity  out  1  XOR of all operand bits.
REQ-014 out_ge  out  1  out_count >= latched threshold.
REQ-015 out_maj  out  1  2*out_count > WIDTH (strict majority).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in_ready SHALL be 0 in BUSY and DONE.
REQ-018 Accept SHALL occur on an edge with in_valid=1 and state IDLE; on accept the block SHALL latch in_data and in_thr, clear the accumulators and beat counter, and go to BUSY.
REQ-019 In BUSY, each cycle SHALL consume lane k = bits [k*LANES +: LANES], LSB lane first, adding its popcount to the count accumulator and XORing its parity into the parity accumulator.
REQ-020 BUSY SHALL last exactly NBEATS cycles; after the edge processing the last lane, the state SHALL be DONE.
REQ-021 In DONE, out_valid SHALL be 1 and all result outputs SHALL be stable until handshake.
REQ-022 On an edge with out_valid=1 and out_ready=1, the state SHALL return to IDLE and out_valid SHALL fall.
REQ-023 Latency SHALL be NBEATS+1 cycles from the accept edge to out_valid high; throughput SHALL be one operand per NBEATS+2 cycles minimum.
REQ-024 out_ready=1 outside DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored, and in_data/in_thr changes after accept SHALL NOT affect the result.
REQ-025 The count accumulator SHALL be CW bits and SHALL never overflow, since max = WIDTH.
REQ-026 in_thr=0 SHALL give out_ge=1; in_thr>WIDTH SHALL give out_ge=0.
REQ-027 out_maj for even WIDTH at count = WIDTH/2 SHALL be 0.
REQ-028 Result outputs SHALL be driven from registers, not combinationally from in_data; outside DONE they SHALL hold their last values and be qualified only by out_valid.
REQ-029 The configuration WIDTH=3, LANES=1, in_thr=2 SHALL give out_ge equal to 3-input majority, and WIDTH=2 parity SHALL equal 2-input XOR.

Reset
REQ-030 rst_n low SHALL, asynchronously, force state IDLE, out_valid=0, out_count=0, out_parity=0, out_ge=0, out_maj=0, the beat counter and accumulators to 0; in_ready SHALL be 1 while reset is released in IDLE.
REQ-031 Reset asserted in BUSY or DONE SHALL abandon the operation, and no result for it SHALL ever be presented.

Structure
REQ-032 Package tpe_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the CW/NBEATS width helper functions.
REQ-033 Sub-module popcount_lane SHALL be a combinational LANES-bit popcount plus parity, instantiated once in the datapath.

Verification
REQ-034 Reset mid-BUSY (WIDTH=8, LANES=1) -> next cycle in_ready=1, out_valid=0, all outputs 0, and no stale result afterwards.
REQ-035 WIDTH=3, LANES=1, all 8 operands 0..7, in_thr=2 -> out_ge matches 3-input majority, out_parity matches 3-input XOR, and out_valid rises 4 cycles after each accept.
REQ-036 WIDTH=8, LANES=4, in_data=8'hB6, in_thr=5 -> out_count=5, out_parity=1, out_ge=1, out_maj=1, latency 3 cycles.
REQ-037 WIDTH=8, in_data=8'h0F, in_thr=0 then 9 -> out_count=4, out_maj=0, out_ge=1 then 0.
REQ-038 out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout, then release -> IDLE in 1 cycle.
REQ-039 in_data toggled every cycle during BUSY (WIDTH=8, LANES=2, accepted 8'hFF) -> out_count=8, out_parity=0.

Source files
------------

// File: rtl/tpe_pkg.sv
// tpe_pkg: FSM state type and width helpers shared by threshold_parity_eval and its lane unit.
package tpe_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int nbeats_of(input int width, input int lanes);
        return width / lanes;
    endfunction

    // Beat counter width; a single-beat operand still needs one bit.
    function automatic int bw_of(input int nbeats);
        return nbeats > 1 ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/threshold_parity_eval_popcount_lane.sv
// popcount_lane: combinational popcount and parity of one LANES-bit slice.
//   i_bits   : lane bits
//   o_count  : number of ones in i_bits
//   o_parity : XOR of i_bits
module popcount_lane #(
    parameter int LANES = 1,
    localparam int LCW = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] i_bits,
    output logic [LCW-1:0]   o_count,
    output logic             o_parity
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < LANES; i++)
            o_count = o_count + LCW'(i_bits[i]);
    end

    assign o_parity = ^i_bits;

endmodule

// File: rtl/threshold_parity_eval.sv
// threshold_parity_eval: serial popcount/parity/threshold/majority of one operand, LANES bits per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake; in_data and in_thr latched on accept
//   out_valid/out_ready  : result handshake
//   out_count/out_parity : popcount and XOR of the operand
//   out_ge/out_maj       : count >= latched threshold, strict majority of WIDTH
module threshold_parity_eval
    import tpe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1,
    localparam int CW = cw_of(WIDTH),
    localparam int NBEATS = nbeats_of(WIDTH, LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CW-1:0]    in_thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_parity,
    output logic             out_ge,
    output logic             out_maj
);

    localparam int BW = bw_of(NBEATS);
    localparam int LCW = $clog2(LANES + 1);
    localparam logic [CW:0] W_FULL = (CW + 1)'(WIDTH);

    if (WIDTH % LANES != 0) begin : g_bad_lanes
        $error("threshold_parity_eval: WIDTH must be a multiple of LANES");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_thr;
    logic [CW-1:0]    r_cnt;
    logic             r_par;
    logic [BW-1:0]    r_beat;
    logic [LCW-1:0]   w_lane_cnt;
    logic             w_lane_par;
    logic [CW-1:0]    w_cnt_nx;
    logic             w_par_nx;
    logic             w_last;
    logic             w_accept;

    // The latched operand is shifted right each beat so the current lane is always at the bottom.
    popcount_lane #(.LANES(LANES)) u_lane (
        .i_bits   (r_data[LANES-1:0]),
        .o_count  (w_lane_cnt),
        .o_parity (w_lane_par)
    );

    assign w_cnt_nx = r_cnt + CW'(w_lane_cnt);
    assign w_par_nx = r_par ^ w_lane_par;
    assign w_last   = r_beat == BW'(NBEATS - 1);
    assign w_accept = r_state == IDLE && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state == IDLE ? (in_valid ? BUSY : IDLE) :
                    r_state == BUSY ? (w_last ? DONE : BUSY) :
                    r_state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
    end

    // Results are registered on the last beat and then held until the next operand completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_thr      <= '0;
            r_cnt      <= '0;
            r_par      <= 1'b0;
            r_beat     <= '0;
            out_count  <= '0;
            out_parity <= 1'b0;
            out_ge     <= 1'b0;
            out_maj    <= 1'b0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_thr  <= in_thr;
            r_cnt  <= '0;
            r_par  <= 1'b0;
            r_beat <= '0;
        end else if (r_state == BUSY) begin
            r_data <= r_data >> LANES;
            r_cnt  <= w_cnt_nx;
            r_par  <= w_par_nx;
            r_beat <= r_beat + 1'b1;
            if (w_last) begin
                out_count  <= w_cnt_nx;
                out_parity <= w_par_nx;
                out_ge     <= w_cnt_nx >= r_thr;
                out_maj    <= {w_cnt_nx, 1'b0} > W_FULL;
            end
        end
    end

endmodule

// File: tb/tb_threshold_parity_eval.sv
// tb_threshold_parity_eval: directed and random checks of threshold_parity_eval in five configurations.
module tb_threshold_parity_eval;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [3:0] dthr;
    logic [4:0] iv, ordy, ir, ov, par, ge, maj;
    logic [3:0] c0, c2, c3;
    logic [1:0] c1, c4;
    int         checks, errors;

    int wd[5] = '{8, 3, 8, 8, 2};
    int nb[5] = '{8, 3, 2, 4, 2};

    threshold_parity_eval #(.WIDTH(8), .LANES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din), .in_thr(dthr),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_count(c0), .out_parity(par[0]), .out_ge(ge[0]), .out_maj(maj[0]));
    threshold_parity_eval #(.WIDTH(3), .LANES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[2:0]), .in_thr(dthr[1:0]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_count(c1), .out_parity(par[1]), .out_ge(ge[1]), .out_maj(maj[1]));
    threshold_parity_eval #(.WIDTH(8), .LANES(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din), .in_thr(dthr),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_count(c2), .out_parity(par[2]), .out_ge(ge[2]), .out_maj(maj[2]));
    threshold_parity_eval #(.WIDTH(8), .LANES(2)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(din), .in_thr(dthr),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_count(c3), .out_parity(par[3]), .out_ge(ge[3]), .out_maj(maj[3]));
    threshold_parity_eval #(.WIDTH(2), .LANES(1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .in_data(din[1:0]), .in_thr(dthr[1:0]),
        .out_valid(ov[4]), .out_ready(ordy[4]), .out_count(c4), .out_parity(par[4]), .out_ge(ge[4]), .out_maj(maj[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] cnt_of(input int d);
        case (d)
            0:       return c0;
            1:       return {2'b00, c1};
            2:       return c2;
            3:       return c3;
            default: return {2'b00, c4};
        endcase
    endfunction

    // Observed status vector: {out_valid, in_ready, parity, ge, maj, count}.
    function automatic logic [8:0] obs(input int d);
        return {ov[d], ir[d], par[d], ge[d], maj[d], cnt_of(d)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Reference: results from the operand's bit count, independent of how it is serialised.
    task automatic op(input int d, input logic [7:0] data, input logic [3:0] thr, input int hold);
        int w, n, tm, lat;
        logic [8:0] e;
        w  = wd[d];
        n  = 0;
        for (int i = 0; i < w; i++) n += int'(data[i]);
        tm = int'(thr) % (1 << $clog2(w + 1));
        e  = {1'b1, 1'b0, n % 2 == 1, n >= tm, 2 * n > w, 4'(n)};
        @(negedge clk);
        din   = data;
        dthr  = thr;
        iv[d] = 1'b1;
        chk($sformatf("ready_d%0d", d), 32'(ir[d]), 32'd1);
        @(negedge clk);
        lat = 1;
        while (ov[d] !== 1'b1 && lat < 64) begin
            iv[d]   = 1'($urandom);
            ordy[d] = 1'($urandom);
            din     = 8'($urandom);
            dthr    = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b0;
        chk($sformatf("latency_d%0d", d), 32'(lat), 32'(nb[d] + 1));
        chk($sformatf("result_d%0d_%0h_%0h", d, data, thr), 32'(obs(d)), 32'(e));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk($sformatf("stall_d%0d_%0d", d, k), 32'(obs(d)), 32'(e));
        end
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        chk($sformatf("release_d%0d", d), 32'(obs(d)), 32'({2'b01, e[6:0]}));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        iv     = '0;
        ordy   = '0;
        din    = '0;
        dthr   = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 5; d++) chk($sformatf("reset_d%0d", d), 32'(obs(d)), 32'h100 >> 1);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) op(1, 8'(v), 4'd2, 0);
        op(2, 8'hB6, 4'd5, 0);
        op(0, 8'h0F, 4'd0, 0);
        op(0, 8'h0F, 4'd9, 0);
        op(3, 8'hFF, 4'd3, 0);
        for (int v = 0; v < 4; v++) op(4, 8'(v), 4'($urandom), 0);
        op(0, 8'hA5, 4'd4, 10);
        op(2, 8'h00, 4'd0, 0);
        op(2, 8'hFF, 4'd8, 0);
        op(0, 8'hF0, 4'd5, 0);
        for (int r = 0; r < 25; r++) op(int'($urandom_range(0, 4)), 8'($urandom), 4'($urandom), int'($urandom_range(0, 2)));

        @(negedge clk);
        din   = 8'hFF;
        dthr  = 4'd0;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_before_reset", 32'(ir[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(obs(0)), 32'h080);
        @(negedge clk);
        chk("reset_mid_busy", 32'(obs(0)), 32'h080);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("no_stale_%0d", k), 32'(obs(0)), 32'h080);
        end
        op(0, 8'h3C, 4'd4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
